// File: rtl/hdmi_fmt_meas.sv
// hdmi_fmt_meas: measures HDMI video timing (active/total width and height)
// from decoded hsync/vsync/de in the rxclk domain. It asserts locked once the
// same valid frame measurement has been seen STABLE_FRAMES times in a row.
// Optional feature macro: HDMI_FMT_POL_EN adds sync polarity detection and
// the hs_pol/vs_pol ports. Without it, syncs are treated as active-high.
module hdmi_fmt_meas #(
  parameter int unsigned CW            = 12,
  parameter int unsigned STABLE_FRAMES = 4
) (
  input  logic          rxclk,
  input  logic          reset,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic          locked,
  output logic          fmt_chg
`ifdef HDMI_FMT_POL_EN
  ,
  output logic          hs_pol,
  output logic          vs_pol
`endif
);

  localparam int unsigned   MW   = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Input register and previous sample
  // ---------------------------------------------------------------------
  logic hs_q, vs_q, de_q;
  logic hs_p_q, vs_p_q, de_p_q;

  // Register the raw inputs once, then keep one older sample for edges
  always_ff @(posedge rxclk) begin
    if (reset) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      hs_p_q <= 1'b0;
      vs_p_q <= 1'b0;
      de_p_q <= 1'b0;
    end else begin
      hs_q   <= hsync;
      vs_q   <= vsync;
      de_q   <= de;
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
      de_p_q <= de_q;
    end
  end

  logic de_rise, de_fall;
  logic hs_act, hs_act_p, vs_act, vs_act_p;
  logic hs_lead, vs_lead;
  logic pol_chg;

  assign de_rise = de_q & ~de_p_q;
  assign de_fall = ~de_q & de_p_q;

`ifdef HDMI_FMT_POL_EN
  logic hs_pol_q, vs_pol_q;

  // Syncs are inactive during active video, so their level at a de rise
  // is the inactive level; the active polarity is its complement
  always_ff @(posedge rxclk) begin
    if (reset) begin
      hs_pol_q <= 1'b1;
      vs_pol_q <= 1'b1;
    end else if (de_rise) begin
      hs_pol_q <= ~hs_q;
      vs_pol_q <= ~vs_q;
    end
  end

  assign hs_act   = (hs_q == hs_pol_q);
  assign hs_act_p = (hs_p_q == hs_pol_q);
  assign vs_act   = (vs_q == vs_pol_q);
  assign vs_act_p = (vs_p_q == vs_pol_q);
  assign pol_chg  = de_rise & (((~hs_q) != hs_pol_q) | ((~vs_q) != vs_pol_q));
  assign hs_pol   = hs_pol_q;
  assign vs_pol   = vs_pol_q;
`else
  assign hs_act   = hs_q;
  assign hs_act_p = hs_p_q;
  assign vs_act   = vs_q;
  assign vs_act_p = vs_p_q;
  assign pol_chg  = 1'b0;
`endif

  assign hs_lead = hs_act & ~hs_act_p;
  assign vs_lead = vs_act & ~vs_act_p;

  // ---------------------------------------------------------------------
  // Line and frame accumulation
  // ---------------------------------------------------------------------
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [CW-1:0] ltot_q, ltot_d;
  logic          ref_vld_q, ref_vld_d;
  logic          ltot_vld_q, ltot_vld_d;
  logic          bad_q, bad_d;
  logic          sat_q, sat_d;
  logic          line_de_q, line_de_d;
  logic          open_q, open_d;

  logic          hcnt_sat;
  logic [CW-1:0] ltot_now;
  logic          tmo;
  logic          m_valid;

  assign hcnt_sat = (hcnt_q == CMAX);
  assign ltot_now = sat_inc(hcnt_q);
  // A missing hsync is only a timeout while the edge has not just arrived
  assign tmo      = (hcnt_sat & ~hs_lead) | (lcnt_q == CMAX);

  assign m_valid = ~bad_q & ~sat_q & ref_vld_q & ltot_vld_q &
                   (ref_q != '0) & (ltot_q != '0) & (acnt_q != '0) & (lcnt_q != '0) &
                   (ref_q != CMAX) & (ltot_q != CMAX) & (acnt_q != CMAX) & (lcnt_q != CMAX);

  // Next-state for line/frame counters and per-frame consistency flags
  always_comb begin
    hcnt_d     = hcnt_q;
    dcnt_d     = dcnt_q;
    lcnt_d     = lcnt_q;
    acnt_d     = acnt_q;
    ref_d      = ref_q;
    ltot_d     = ltot_q;
    ref_vld_d  = ref_vld_q;
    ltot_vld_d = ltot_vld_q;
    bad_d      = bad_q;
    sat_d      = sat_q;
    line_de_d  = line_de_q;
    open_d     = open_q;

    hcnt_d = hs_lead ? '0 : sat_inc(hcnt_q);

    if (de_q) begin
      dcnt_d = de_rise ? CW'(1) : sat_inc(dcnt_q);
    end

    // Close a line: count it and check its length against the frame's first
    if (hs_lead) begin
      line_de_d = 1'b0;
      lcnt_d    = sat_inc(lcnt_q);
      if (hcnt_sat) begin
        sat_d = 1'b1;
      end
      if (!ltot_vld_q) begin
        ltot_d     = ltot_now;
        ltot_vld_d = 1'b1;
      end else if (ltot_now != ltot_q) begin
        bad_d = 1'b1;
      end
    end

    // Close a de run: first run is the reference, any other length spoils
    if (de_fall) begin
      if (dcnt_q == CMAX) begin
        sat_d = 1'b1;
      end
      if (!ref_vld_q) begin
        ref_d     = dcnt_q;
        ref_vld_d = 1'b1;
      end else if (dcnt_q != ref_q) begin
        bad_d = 1'b1;
      end
    end

    // A de rise coincident with hsync belongs to the new line
    if (de_rise && (!line_de_q || hs_lead)) begin
      line_de_d = 1'b1;
      acnt_d    = sat_inc(acnt_q);
      if (acnt_q == CMAX) begin
        sat_d = 1'b1;
      end
    end

    // Frame boundary: a coincident hsync edge opens line 0 of the new frame
    if (vs_lead) begin
      open_d     = 1'b1;
      lcnt_d     = hs_lead ? CW'(1) : '0;
      acnt_d     = de_rise ? CW'(1) : '0;
      line_de_d  = de_rise;
      ref_d      = '0;
      ref_vld_d  = 1'b0;
      ltot_d     = '0;
      ltot_vld_d = 1'b0;
      bad_d      = 1'b0;
      sat_d      = 1'b0;
    end

    // Timeout discards the partial frame; the next vsync only reopens
    if (tmo) begin
      open_d     = 1'b0;
      lcnt_d     = '0;
      acnt_d     = '0;
      line_de_d  = 1'b0;
      ref_d      = '0;
      ref_vld_d  = 1'b0;
      ltot_d     = '0;
      ltot_vld_d = 1'b0;
      bad_d      = 1'b0;
      sat_d      = 1'b0;
    end
  end

  // Line/frame accumulator registers
  always_ff @(posedge rxclk) begin
    if (reset) begin
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      lcnt_q     <= '0;
      acnt_q     <= '0;
      ref_q      <= '0;
      ltot_q     <= '0;
      ref_vld_q  <= 1'b0;
      ltot_vld_q <= 1'b0;
      bad_q      <= 1'b0;
      sat_q      <= 1'b0;
      line_de_q  <= 1'b0;
      open_q     <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      lcnt_q     <= lcnt_d;
      acnt_q     <= acnt_d;
      ref_q      <= ref_d;
      ltot_q     <= ltot_d;
      ref_vld_q  <= ref_vld_d;
      ltot_vld_q <= ltot_vld_d;
      bad_q      <= bad_d;
      sat_q      <= sat_d;
      line_de_q  <= line_de_d;
      open_q     <= open_d;
    end
  end

  // ---------------------------------------------------------------------
  // Closed-frame measurement stage
  // ---------------------------------------------------------------------
  logic          close_q, tmo_q, polchg_q, mval_q;
  logic [CW-1:0] m_run_q, m_ltot_q, m_acnt_q, m_lcnt_q;

  // Capture M and the frame events for the lock state machine
  always_ff @(posedge rxclk) begin
    if (reset) begin
      close_q  <= 1'b0;
      tmo_q    <= 1'b0;
      polchg_q <= 1'b0;
      mval_q   <= 1'b0;
      m_run_q  <= '0;
      m_ltot_q <= '0;
      m_acnt_q <= '0;
      m_lcnt_q <= '0;
    end else begin
      close_q  <= vs_lead & open_q & ~tmo;
      tmo_q    <= tmo;
      polchg_q <= pol_chg;
      mval_q   <= m_valid;
      m_run_q  <= ref_q;
      m_ltot_q <= ltot_q;
      m_acnt_q <= acnt_q;
      m_lcnt_q <= lcnt_q;
    end
  end

  // ---------------------------------------------------------------------
  // Lock state machine and output registers
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [MW-1:0] match_inc;
  logic [CW-1:0] cand_run_q, cand_run_d, cand_ltot_q, cand_ltot_d;
  logic [CW-1:0] cand_acnt_q, cand_acnt_d, cand_lcnt_q, cand_lcnt_d;
  logic [CW-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
  logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic          locked_q, locked_d, fmt_chg_q, fmt_chg_d;
  logic          m_eq;

  assign match_inc = match_q + MW'(1);
  assign m_eq      = (m_run_q == cand_run_q) & (m_ltot_q == cand_ltot_q) &
                     (m_acnt_q == cand_acnt_q) & (m_lcnt_q == cand_lcnt_q);

  // Next state, candidate tracking and output values
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    cand_run_d  = cand_run_q;
    cand_ltot_d = cand_ltot_q;
    cand_acnt_d = cand_acnt_q;
    cand_lcnt_d = cand_lcnt_q;
    h_active_d  = h_active_q;
    v_active_d  = v_active_q;
    h_total_d   = h_total_q;
    v_total_d   = v_total_q;
    locked_d    = locked_q;
    fmt_chg_d   = 1'b0;

    if (tmo_q || (polchg_q && state_q == LOCKED)) begin
      state_d    = SEARCH;
      match_d    = '0;
      h_active_d = '0;
      v_active_d = '0;
      h_total_d  = '0;
      v_total_d  = '0;
      locked_d   = 1'b0;
    end else if (close_q) begin
      case (state_q)
        SEARCH: begin
          if (mval_q) begin
            cand_run_d  = m_run_q;
            cand_ltot_d = m_ltot_q;
            cand_acnt_d = m_acnt_q;
            cand_lcnt_d = m_lcnt_q;
            match_d     = MW'(1);
            state_d     = CHECK;
          end
        end
        CHECK: begin
          if (mval_q && m_eq) begin
            match_d = match_inc;
            if (match_inc == MW'(STABLE_FRAMES)) begin
              state_d    = LOCKED;
              h_active_d = cand_run_q;
              h_total_d  = cand_ltot_q;
              v_active_d = cand_acnt_q;
              v_total_d  = cand_lcnt_q;
              locked_d   = 1'b1;
              fmt_chg_d  = 1'b1;
            end
          end else if (mval_q) begin
            cand_run_d  = m_run_q;
            cand_ltot_d = m_ltot_q;
            cand_acnt_d = m_acnt_q;
            cand_lcnt_d = m_lcnt_q;
            match_d     = MW'(1);
          end else begin
            match_d = '0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (!(mval_q && m_eq)) begin
            state_d    = SEARCH;
            match_d    = '0;
            h_active_d = '0;
            v_active_d = '0;
            h_total_d  = '0;
            v_total_d  = '0;
            locked_d   = 1'b0;
          end
        end
        default: begin
          state_d = SEARCH;
          match_d = '0;
        end
      endcase
    end
  end

  // State, candidate and output registers
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q     <= SEARCH;
      match_q     <= '0;
      cand_run_q  <= '0;
      cand_ltot_q <= '0;
      cand_acnt_q <= '0;
      cand_lcnt_q <= '0;
      h_active_q  <= '0;
      v_active_q  <= '0;
      h_total_q   <= '0;
      v_total_q   <= '0;
      locked_q    <= 1'b0;
      fmt_chg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      cand_run_q  <= cand_run_d;
      cand_ltot_q <= cand_ltot_d;
      cand_acnt_q <= cand_acnt_d;
      cand_lcnt_q <= cand_lcnt_d;
      h_active_q  <= h_active_d;
      v_active_q  <= v_active_d;
      h_total_q   <= h_total_d;
      v_total_q   <= v_total_d;
      locked_q    <= locked_d;
      fmt_chg_q   <= fmt_chg_d;
    end
  end

  assign h_active = h_active_q;
  assign v_active = v_active_q;
  assign h_total  = h_total_q;
  assign v_total  = v_total_q;
  assign locked   = locked_q;
  assign fmt_chg  = fmt_chg_q;

endmodule
